// File: rtl/tdm_demux_1to4_pkg.sv
// Shared constants and types for the 4-slot TDM receive demux.
// Slot count, slot index width and framing state encoding.
package tdm_demux_1to4_pkg;

    localparam int SLOTS  = 4;
    localparam int SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux_1to4.sv
// Receive end of a 4-slot TDM link: routes frame beat k to out<k>.
// Partial frames sit in shadow regs so out0..out3 only change on a whole frame.
module tdm_demux_1to4
    import tdm_demux_1to4_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_sync,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3,
    output logic         out_valid,
    output logic [1:0]   slot,
    output logic         sync_err
);

    localparam slot_t LAST = slot_t'(SLOTS - 1);
    localparam slot_t ONE  = slot_t'(1);

    state_t       state;
    slot_t        idx;
    logic [W-1:0] sh0;
    logic [W-1:0] sh1;
    logic [W-1:0] sh2;

    assign slot = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            idx       <= '0;
            sh0       <= '0;
            sh1       <= '0;
            sh2       <= '0;
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (in_valid) begin
                unique case (state)
                    HUNT: begin
                        if (in_sync) begin
                            sh0   <= in_data;
                            idx   <= ONE;
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (in_sync) begin
                            // a sync mid-frame restarts alignment on this beat
                            sync_err <= (idx != '0);
                            sh0      <= in_data;
                            idx      <= ONE;
                        end else if (idx == '0) begin
                            sync_err <= 1'b1;
                            idx      <= '0;
                            state    <= HUNT;
                        end else if (idx == LAST) begin
                            out0      <= sh0;
                            out1      <= sh1;
                            out2      <= sh2;
                            out3      <= in_data;
                            out_valid <= 1'b1;
                            idx       <= '0;
                        end else begin
                            unique case (idx)
                                2'd1:    sh1 <= in_data;
                                default: sh2 <= in_data;
                            endcase
                            idx <= idx + ONE;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Directed bench for tdm_demux_1to4 with a frame scoreboard.
// Expected frames are queued as beats are driven and popped on out_valid.
module tb_tdm_demux_1to4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_sync = 1'b0;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] out3;
    logic       out_valid;
    logic [1:0] slot;
    logic       sync_err;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sb[$];

    tdm_demux_1to4 #(.W(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_sync(in_sync),
        .out0(out0),
        .out1(out1),
        .out2(out2),
        .out3(out3),
        .out_valid(out_valid),
        .slot(slot),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: one entry per frame the DUT must deliver
    always @(negedge clk) begin
        chk("excl", {31'd0, out_valid & sync_err}, 32'd0);
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                chk("frame", {out0, out1, out2, out3}, sb.pop_front());
            end
        end
    end

    // drive one beat starting at a negedge, check at the following negedge
    task automatic beat(input logic [7:0] d, input logic s,
                        input logic eov, input logic eerr,
                        input logic [1:0] eslot);
        in_valid = 1'b1;
        in_data  = d;
        in_sync  = s;
        @(negedge clk);
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = 8'hEE;
        chk($sformatf("out_valid_%h", d), {31'd0, out_valid}, {31'd0, eov});
        chk($sformatf("sync_err_%h", d), {31'd0, sync_err}, {31'd0, eerr});
        chk($sformatf("slot_%h", d), {30'd0, slot}, {30'd0, eslot});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
            chk("idle_sync_err", {31'd0, sync_err}, 32'd0);
        end
    endtask

    task automatic outs(input string tag, input logic [31:0] exp);
        chk(tag, {out0, out1, out2, out3}, exp);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        outs("reset_outs", 32'h0);
        chk("reset_slot", {30'd0, slot}, 32'd0);
        chk("reset_ov", {31'd0, out_valid}, 32'd0);
        chk("reset_err", {31'd0, sync_err}, 32'd0);
        rst = 1'b0;

        // back-to-back frame, accepted on the first edge after reset
        sb.push_back(32'h11223344);
        beat(8'h11, 1, 0, 0, 2'd1);
        beat(8'h22, 0, 0, 0, 2'd2);
        beat(8'h33, 0, 0, 0, 2'd3);
        outs("held_before_slot3", 32'h0);
        beat(8'h44, 0, 1, 0, 2'd0);
        idle(1);

        // same frame with two idle cycles between beats
        sb.push_back(32'h11223344);
        beat(8'h11, 1, 0, 0, 2'd1);
        idle(2);
        beat(8'h22, 0, 0, 0, 2'd2);
        idle(2);
        beat(8'h33, 0, 0, 0, 2'd3);
        idle(2);
        beat(8'h44, 0, 1, 0, 2'd0);
        idle(1);

        // missing sync after a complete frame drops back to HUNT
        beat(8'h99, 0, 0, 1, 2'd0);
        outs("keep_after_err", 32'h11223344);

        // unsynced beats in HUNT are silently dropped
        beat(8'hAA, 0, 0, 0, 2'd0);
        beat(8'hBB, 0, 0, 0, 2'd0);
        sb.push_back(32'h55667788);
        beat(8'h55, 1, 0, 0, 2'd1);
        beat(8'h66, 0, 0, 0, 2'd2);
        beat(8'h77, 0, 0, 0, 2'd3);
        beat(8'h88, 0, 1, 0, 2'd0);

        // early sync restarts the frame
        beat(8'h01, 1, 0, 0, 2'd1);
        beat(8'h02, 0, 0, 0, 2'd2);
        sb.push_back(32'h05060708);
        beat(8'h05, 1, 0, 1, 2'd1);
        outs("keep_before_resync", 32'h55667788);
        beat(8'h06, 0, 0, 0, 2'd2);
        beat(8'h07, 0, 0, 0, 2'd3);
        beat(8'h08, 0, 1, 0, 2'd0);

        // asynchronous reset mid-frame
        beat(8'hC1, 1, 0, 0, 2'd1);
        beat(8'hC2, 0, 0, 0, 2'd2);
        beat(8'hC3, 0, 0, 0, 2'd3);
        #2 rst = 1'b1;
        #1;
        outs("async_rst_outs", 32'h0);
        chk("async_rst_slot", {30'd0, slot}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(32'hD1D2D3D4);
        beat(8'hD1, 1, 0, 0, 2'd1);
        beat(8'hD2, 0, 0, 0, 2'd2);
        beat(8'hD3, 0, 0, 0, 2'd3);
        beat(8'hD4, 0, 1, 0, 2'd0);
        idle(3);

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
